// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a combinational instruction
// memory and buffers fetched {pc, word} pairs in a small circular FIFO for decode.
module fetch_ctrl #(
  parameter int          ADDR_W     = 32,
  parameter int unsigned RESET_PC   = 0,
  parameter int unsigned IMEM_BYTES = 16,
  parameter int          DEPTH      = 2,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              program_end,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0]  DEPTH_C  = OCC_W'(DEPTH);
  localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(IMEM_BYTES);
  localparam logic [ADDR_W-1:0] PC_RST   = ADDR_W'(RESET_PC) & ~ADDR_W'(3);

  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [OCC_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_fetch_count;
  logic              r_program_end;
  logic [31:0]       r_data [DEPTH];
  logic [ADDR_W-1:0] r_pcs  [DEPTH];

  logic              w_pop;
  logic              w_can_fetch;
  logic              w_push;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [OCC_W-1:0]  w_count_next;
  logic              w_unused;

  // Handshake: the head transfers to decode on any cycle where inst_valid and
  // inst_ready are both high; head outputs never change while valid && !ready.
  assign w_pop         = inst_valid && inst_ready;
  assign w_can_fetch   = (r_pc < END_ADDR) && ((r_count < DEPTH_C) || w_pop);
  assign w_push        = w_can_fetch && !redirect_valid;
  assign w_redirect_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_unused      = ^redirect_pc[1:0];

  always_comb begin
    w_pc_next    = r_pc;
    w_count_next = r_count;
    if (redirect_valid) begin
      w_pc_next    = w_redirect_pc;
      w_count_next = '0;
    end else begin
      if (w_push) w_pc_next = r_pc + ADDR_W'(4);
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + OCC_W'(1);
        2'b01:   w_count_next = r_count - OCC_W'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= PC_RST;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_fetch_count <= '0;
      r_program_end <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_count <= w_count_next;
      // A redirect flushes by collapsing both pointers; a same-cycle pop is absorbed.
      if (redirect_valid) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PTR_W'(1);
        if (w_pop)  r_head <= r_head + PTR_W'(1);
      end
      if (w_push && (r_fetch_count != '1)) r_fetch_count <= r_fetch_count + CNT_W'(1);
      r_program_end <= (w_pc_next >= END_ADDR) && (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_data[r_tail] <= imem_data;
      r_pcs[r_tail]  <= r_pc;
    end
  end

  assign imem_addr   = r_pc;
  assign inst_valid  = (r_count != '0);
  assign inst_out    = inst_valid ? r_data[r_head] : 32'h0;
  assign inst_pc     = inst_valid ? r_pcs[r_head] : '0;
  assign program_end = r_program_end;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a table of per-cycle vectors plus hand-written
// sequences for back-pressure, reset mid-stream and in-order delivery.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        program_end;
  logic [15:0] fetch_count;

  logic [31:0] prog [4];
  logic [31:0] exp_q [$];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_out;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    logic        e_end;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vq [$];

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .program_end(program_end), .fetch_count(fetch_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_data = (imem_addr < 32'd16) ? prog[imem_addr[3:2]] : 32'h0;

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_out(input string name, input logic ev, input logic [31:0] eo,
                           input logic [31:0] ep, input logic [31:0] ea,
                           input logic ee, input logic [15:0] ec);
    n_vec++;
    if (inst_valid !== ev || inst_out !== eo || inst_pc !== ep ||
        imem_addr !== ea || program_end !== ee || fetch_count !== ec) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b out=%h pc=%h addr=%h end=%0b cnt=%0d, want valid=%0b out=%h pc=%h addr=%h end=%0b cnt=%0d",
               name, inst_valid, inst_out, inst_pc, imem_addr, program_end, fetch_count,
               ev, eo, ep, ea, ee, ec);
    end
  endtask

  task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic ev, input logic [31:0] eo, input logic [31:0] ep,
                     input logic [31:0] ea, input logic ee, input logic [15:0] ec);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = ev; v.e_out = eo; v.e_pc = ep; v.e_addr = ea; v.e_end = ee; v.e_cnt = ec;
    vq.push_back(v);
  endtask

  initial begin
    prog[0] = 32'h00221825; prog[1] = 32'h24A40015;
    prog[2] = 32'hACE60005; prog[3] = 32'h11280007;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Per-cycle table: inputs for the cycle, outputs expected during that cycle.
    //  rst rv  rpc     rdy  valid out           pc     addr   end cnt
    add(0, 0, 32'h0,  1,   0, 32'h0,        32'h0, 32'h0,  0, 0);   // streaming from reset
    add(0, 0, 32'h0,  1,   1, 32'h00221825, 32'h0, 32'h4,  0, 1);
    add(0, 0, 32'h0,  1,   1, 32'h24A40015, 32'h4, 32'h8,  0, 2);
    add(0, 0, 32'h0,  1,   1, 32'hACE60005, 32'h8, 32'hC,  0, 3);
    add(0, 0, 32'h0,  1,   1, 32'h11280007, 32'hC, 32'h10, 0, 4);
    add(0, 0, 32'h0,  1,   0, 32'h0,        32'h0, 32'h10, 1, 4);   // end of program
    add(0, 1, 32'h0,  1,   0, 32'h0,        32'h0, 32'h10, 1, 4);   // redirect to 0
    add(0, 0, 32'h0,  1,   0, 32'h0,        32'h0, 32'h0,  0, 4);
    add(0, 1, 32'h6,  1,   1, 32'h00221825, 32'h0, 32'h4,  0, 5);   // redirect 0x6 with pop
    add(0, 0, 32'h0,  1,   0, 32'h0,        32'h0, 32'h4,  0, 5);
    add(0, 1, 32'hC,  1,   1, 32'h24A40015, 32'h4, 32'h8,  0, 6);   // redirect 0xC with pop
    add(0, 0, 32'h0,  0,   0, 32'h0,        32'h0, 32'hC,  0, 6);
    add(0, 0, 32'h0,  0,   1, 32'h11280007, 32'hC, 32'h10, 0, 7);
    add(0, 0, 32'h0,  0,   1, 32'h11280007, 32'hC, 32'h10, 0, 7);   // stalled head stable
    add(0, 0, 32'h0,  1,   1, 32'h11280007, 32'hC, 32'h10, 0, 7);
    add(0, 1, 32'h23, 1,   0, 32'h0,        32'h0, 32'h10, 1, 7);   // redirect past end
    add(0, 0, 32'h0,  1,   0, 32'h0,        32'h0, 32'h20, 1, 7);

    do_reset(2);
    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; redirect_valid = vq[i].rv;
      redirect_pc = vq[i].rpc; inst_ready = vq[i].rdy;
      #1;
      check_out($sformatf("vec%0d", i), vq[i].e_valid, vq[i].e_out, vq[i].e_pc,
                vq[i].e_addr, vq[i].e_end, vq[i].e_cnt);
      @(negedge clk);
    end
    redirect_valid = 1'b0;

    // Back-pressure: buffer fills to DEPTH and PC parks at 8.
    do_reset(1);
    check_out("reset_state", 0, 32'h0, 32'h0, 32'h0, 0, 0);
    repeat (5) @(negedge clk);
    check_out("full_hold", 1, 32'h00221825, 32'h0, 32'h8, 0, 2);

    // Release ready: every word delivered once, in order, then end of program.
    for (int k = 0; k < 4; k++) exp_q.push_back(prog[k]);
    inst_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      #1;
      if (inst_valid) begin
        logic [31:0] exp_w;
        exp_w = exp_q.pop_front();
        n_vec++;
        if (inst_out !== exp_w || inst_pc !== 32'(4 * (3 - exp_q.size()))) begin
          n_bad++;
          $display("FAIL drain_order: got out=%h pc=%h, want out=%h pc=%h",
                   inst_out, inst_pc, exp_w, 32'(4 * (3 - exp_q.size())));
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d words left, want 0", exp_q.size());
    end
    check_out("drain_end", 0, 32'h0, 32'h0, 32'h10, 1, 4);

    // Reset mid-stream while full and ready toggling.
    do_reset(1);
    repeat (3) @(negedge clk);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check_out("pre_reset", 1, 32'h24A40015, 32'h4, 32'hC, 0, 3);
    @(negedge clk);
    reset = 1'b1; inst_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_out("mid_reset", 0, 32'h0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    check_out("restart", 1, 32'h00221825, 32'h0, 32'h4, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
